// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters in bursts of up to BURST_MAX beats.
// Optional stall counter (stall_clr / stall_cnt ports) is built when FIFO_WR_ARB_STALL_CNT_EN is defined.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                      write_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      fifo_full,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    input  logic                      stall_clr,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     owner, owner_n;
    logic [IDX_W-1:0]     last_owner, last_owner_n;
    logic [CNT_W-1:0]     beat_cnt, beat_cnt_n;
    logic [NUM_REQ-1:0]   grant_n;

    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic                 owner_req;
    logic [DATA_W-1:0]    owner_data;
    logic [CNT_W-1:0]     cnt_inc;

    // Search upward from the requester after last_owner, wrapping at NUM_REQ.
    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        jj       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(last_owner) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = IDX_W'(j);
            if (!pick_vld && req[jj]) begin
                pick_vld = 1'b1;
                pick_idx = jj;
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner == IDX_W'(k)) begin
                owner_req  = req[k];
                owner_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Gated by reset so the write strobe drops the instant reset asserts.
    assign fifo_write_en = reset && (state == GRANT) && owner_req && !fifo_full;
    assign fifo_data     = fifo_write_en ? owner_data : '0;
    assign busy          = (state == GRANT);
    assign cnt_inc       = beat_cnt + 1'b1;

    always_comb begin
        ack = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (fifo_write_en && owner == IDX_W'(k)) ack[k] = 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        beat_cnt_n   = beat_cnt;
        grant_n      = grant;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n    = GRANT;
                    owner_n    = pick_idx;
                    grant_n    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    beat_cnt_n = '0;
                end
            end
            GRANT: begin
                if (!owner_req || (fifo_write_en && cnt_inc == CNT_W'(BURST_MAX))) begin
                    state_n      = IDLE;
                    grant_n      = '0;
                    last_owner_n = owner;
                    beat_cnt_n   = '0;
                end else if (fifo_write_en) begin
                    beat_cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
            grant      <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            beat_cnt   <= beat_cnt_n;
            grant      <= grant_n;
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    // Cycles the owner had a beat ready but the FIFO was full; saturating.
    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if ((state == GRANT) && owner_req && fifo_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-requester source queues feed the DUT, a scoreboard holds expected beats in grant order.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;

    logic                      write_clk = 1'b0;
    logic                      reset     = 1'b0;
    logic [NUM_REQ-1:0]        req       = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        grant;
    logic                      fifo_full = 1'b0;
    logic                      fifo_write_en;
    logic [DATA_W-1:0]         fifo_data;
    logic                      busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic                      stall_clr = 1'b0;
    logic [15:0]               stall_cnt;
`endif

    always #5 write_clk = ~write_clk;

    fifo_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .write_clk     (write_clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .grant         (grant),
        .fifo_full     (fifo_full),
        .fifo_write_en (fifo_write_en),
        .fifo_data     (fifo_data),
        .busy          (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        ,
        .stall_clr     (stall_clr),
        .stall_cnt     (stall_cnt)
`endif
    );

    typedef struct {
        int                who;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] src_q[NUM_REQ][$];
    int                n_assert = 0;
    int                n_fail   = 0;
    logic              rand_full = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NUM_REQ; k++) begin
            req[k] = (src_q[k].size() != 0);
            req_data[k*DATA_W +: DATA_W] = req[k] ? src_q[k][0] : '0;
        end
    endtask

    task automatic load(input int who, input logic [DATA_W-1:0] d, input bit expect_it);
        beat_t e;
        src_q[who].push_back(d);
        if (expect_it) begin
            e.who = who;
            e.d   = d;
            exp_q.push_back(e);
        end
    endtask

    // One clock: check outputs at negedge, then update requester queues after the edge.
    task automatic tick(output logic we);
        beat_t              e;
        logic [NUM_REQ-1:0] acked;
        @(negedge write_clk);
        we    = fifo_write_en;
        acked = ack;
        if (fifo_write_en) begin
            if (exp_q.size() == 0) begin
                e.who = 31;
                e.d   = '0;
            end else begin
                e = exp_q.pop_front();
            end
            chk("ack_owner", 32'(ack), 32'(1) << e.who);
            chk("beat_data", 32'(fifo_data), 32'(e.d));
            chk("grant_vs_ack", 32'(grant), 32'(ack));
        end else begin
            chk("ack_idle", 32'(ack), 32'd0);
        end
        @(posedge write_clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (acked[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
        end
        if (rand_full) fifo_full = 1'($urandom_range(0, 1));
        drive();
    endtask

    task automatic run_until_empty(input int max_ticks, output int ticks, output int gaps);
        logic we;
        ticks = 0;
        gaps  = 0;
        while (exp_q.size() != 0 && ticks < max_ticks) begin
            tick(we);
            ticks++;
            if (!we) gaps++;
        end
        chk("drain_in_budget", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        fifo_full = 1'b0;
        rand_full = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
        drive();
        repeat (2) @(posedge write_clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(fifo_write_en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t, g;
        logic we;

        // Single requester 2, six beats: burst of 4, one idle cycle, burst of 2.
        do_reset();
        for (int i = 0; i < 6; i++) load(2, 8'hA0 + 8'(i), 1'b1);
        drive();
        tick(we);
        chk("t1_grant_latency", 32'(grant), 32'b0100);
        run_until_empty(100, t, g);
        chk("t1_ticks", 32'(t), 32'd7);
        chk("t1_gaps", 32'(g), 32'd1);
        chk("t1_hold_after_drain", 32'(grant), 32'b0100);
        tick(we);
        chk("t1_release_grant", 32'(grant), 32'd0);
        chk("t1_release_busy", 32'(busy), 32'd0);

        // All four requesting: order 0,1,2,3,0 with one idle cycle per re-arbitration.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < 4; i++) load(k, 8'(16*k + i), 1'b1);
        for (int i = 4; i < 8; i++) load(0, 8'(i), 1'b1);
        drive();
        run_until_empty(200, t, g);
        chk("t2_ticks", 32'(t), 32'd25);
        chk("t2_gaps", 32'(g), 32'd5);

        // Requester 1 stalls on fifo_full after two beats.
        do_reset();
        for (int i = 0; i < 4; i++) load(1, 8'hB0 + 8'(i), 1'b1);
        drive();
        repeat (3) tick(we);
        chk("t3_grant", 32'(grant), 32'b0010);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(we);
            chk("t3_stall_we", 32'(we), 32'd0);
            chk("t3_stall_grant", 32'(grant), 32'b0010);
        end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        chk("t3_stall_cnt", 32'(stall_cnt), 32'd5);
        stall_clr = 1'b1;
`endif
        tick(we);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        stall_clr = 1'b0;
        chk("t3_stall_clr_wins", 32'(stall_cnt), 32'd0);
`endif
        chk("t3_grant_kept", 32'(grant), 32'b0010);
        fifo_full = 1'b0;
        run_until_empty(20, t, g);
        chk("t3_resume_ticks", 32'(t), 32'd2);
        chk("t3_release", 32'(grant), 32'd0);

        // Requester 3 drains after one beat while req[0] waits; pointer wraps 3 -> 0.
        do_reset();
        load(3, 8'hC3, 1'b1);
        drive();
        tick(we);
        chk("t4_grant3", 32'(grant), 32'b1000);
        load(0, 8'hD0, 1'b1);
        drive();
        tick(we);
        chk("t4_hold", 32'(grant), 32'b1000);
        tick(we);
        chk("t4_idle_grant", 32'(grant), 32'd0);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        tick(we);
        chk("t4_wrap_grant", 32'(grant), 32'b0001);
        run_until_empty(10, t, g);

        // Reset asserted while the second beat of a burst is on the bus.
        do_reset();
        load(0, 8'hE0, 1'b1);
        for (int i = 1; i < 4; i++) load(0, 8'hE0 + 8'(i), 1'b0);
        drive();
        repeat (2) tick(we);
        chk("t5_inflight", 32'(fifo_write_en), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant), 32'd0);
        chk("t5_async_ack", 32'(ack), 32'd0);
        chk("t5_async_we", 32'(fifo_write_en), 32'd0);
        chk("t5_scoreboard", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
        drive();
        @(posedge write_clk);
        #1;
        reset = 1'b1;
        load(1, 8'hF1, 1'b1);
        load(3, 8'hF3, 1'b1);
        drive();
        tick(we);
        chk("t5_first_grant", 32'(grant), 32'b0010);
        run_until_empty(20, t, g);

        // Four requesters, six tagged beats each, with random FIFO back-pressure.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < 6; i++) load(k, 8'(16*k + i), 1'b0);
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 0; i < 4; i++) begin
                beat_t e;
                e.who = k;
                e.d   = 8'(16*k + i);
                exp_q.push_back(e);
            end
        for (int k = 0; k < NUM_REQ; k++)
            for (int i = 4; i < 6; i++) begin
                beat_t e;
                e.who = k;
                e.d   = 8'(16*k + i);
                exp_q.push_back(e);
            end
        rand_full = 1'b1;
        drive();
        run_until_empty(600, t, g);
        rand_full = 1'b0;
        fifo_full = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) chk("t6_src_drained", 32'(src_q[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
